// File: rtl/uart_rx_deserializer.sv
// UART receive front end: 2-flop synchronizer, mid-bit sampling FSM, per-byte parity/framing flags.
// Optional build macro UART_RX_MAJORITY_VOTE_EN selects 2-of-3 majority sampling around mid-bit.
module uart_rx_deserializer #(
  parameter int CLOCK_FREQUENCY    = 50_000_000,
  parameter int BAUD_RATE          = 115_200,
  parameter int INCLUDE_PARITY_BIT = 1,
  parameter int STOP_BITS          = 1
) (
  input  logic       clock,
  input  logic       clear,
  input  logic       uart_rx,
  output logic       data_out_valid,
  output logic [7:0] data_out,
  output logic       parity_error,
  output logic       stop_bit_unstable
);

  localparam int CLOCKS_PER_BIT = CLOCK_FREQUENCY / BAUD_RATE;
  localparam int CW             = (CLOCKS_PER_BIT > 1) ? $clog2(CLOCKS_PER_BIT) : 1;

`ifdef UART_RX_MAJORITY_VOTE_EN
  localparam int SAMPLE_DELAY = 1;
  localparam int MIN_CPB      = 6;
`else
  localparam int SAMPLE_DELAY = 0;
  localparam int MIN_CPB      = 4;
`endif

  localparam logic [CW-1:0] START_SAMPLE = CW'(CLOCKS_PER_BIT / 2 - 1 + SAMPLE_DELAY);
  localparam logic [CW-1:0] LAST_COUNT   = CW'(CLOCKS_PER_BIT - 1);
  localparam logic          LAST_STOP    = 1'(STOP_BITS - 1);

  if (CLOCKS_PER_BIT < MIN_CPB) begin : g_cpb_check
    $error("uart_rx_deserializer: CLOCKS_PER_BIT too small for the selected sampling mode");
  end
  if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_stop_check
    $error("uart_rx_deserializer: STOP_BITS must be 1 or 2");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  // Even parity: data plus parity bit must hold an even number of ones.
  function automatic logic parity_mismatch(input logic [7:0] data, input logic par_bit);
    parity_mismatch = (^data) ^ par_bit;
  endfunction

  function automatic logic majority3(input logic a, input logic b, input logic c);
    majority3 = (a & b) | (a & c) | (b & c);
  endfunction

  state_t        state_q;
  logic [CW-1:0] count_q;
  logic [2:0]    bit_idx_q;
  logic          stop_idx_q;
  logic [7:0]    shift_q;
  logic          parity_err_q;
  logic          stop_err_q;
  logic          rx_meta_q;
  logic          rx_s_q;
  logic          valid_q;
  logic [7:0]    data_q;
  logic          parity_out_q;
  logic          stop_out_q;
  logic          sample_bit_d;
  logic          count_wrap_d;

`ifdef UART_RX_MAJORITY_VOTE_EN
  logic [1:0] rx_hist_q;

  // Two previous rx_s values; with the current one they span mid-1..mid+1 at the sample point.
  always_ff @(posedge clock) begin
    if (!clear) begin
      rx_hist_q <= 2'b11;
    end else begin
      rx_hist_q <= {rx_hist_q[0], rx_s_q};
    end
  end

  assign sample_bit_d = majority3(rx_s_q, rx_hist_q[0], rx_hist_q[1]);
`else
  assign sample_bit_d = rx_s_q;
`endif

  assign count_wrap_d = (count_q == LAST_COUNT);

  // Synchronizer, receive FSM and registered byte outputs.
  always_ff @(posedge clock) begin
    if (!clear) begin
      rx_meta_q    <= 1'b1;
      rx_s_q       <= 1'b1;
      state_q      <= S_IDLE;
      count_q      <= '0;
      bit_idx_q    <= 3'd0;
      stop_idx_q   <= 1'b0;
      shift_q      <= 8'd0;
      parity_err_q <= 1'b0;
      stop_err_q   <= 1'b0;
      valid_q      <= 1'b0;
      data_q       <= 8'd0;
      parity_out_q <= 1'b0;
      stop_out_q   <= 1'b0;
    end else begin
      rx_meta_q    <= uart_rx;
      rx_s_q       <= rx_meta_q;
      valid_q      <= 1'b0;
      parity_out_q <= 1'b0;
      stop_out_q   <= 1'b0;

      case (state_q)
        S_IDLE: begin
          count_q <= '0;
          if (!rx_s_q) begin
            state_q <= S_START;
          end
        end

        S_START: begin
          if (count_q == START_SAMPLE) begin
            count_q <= '0;
            if (sample_bit_d) begin
              state_q <= S_IDLE;
            end else begin
              bit_idx_q <= 3'd0;
              state_q   <= S_DATA;
            end
          end else begin
            count_q <= count_q + 1'b1;
          end
        end

        S_DATA: begin
          if (count_wrap_d) begin
            count_q   <= '0;
            shift_q   <= {sample_bit_d, shift_q[7:1]};
            bit_idx_q <= bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) begin
              stop_idx_q <= 1'b0;
              if (INCLUDE_PARITY_BIT != 0) begin
                state_q <= S_PARITY;
              end else begin
                state_q <= S_STOP;
              end
            end
          end else begin
            count_q <= count_q + 1'b1;
          end
        end

        S_PARITY: begin
          if (count_wrap_d) begin
            count_q      <= '0;
            parity_err_q <= parity_mismatch(shift_q, sample_bit_d);
            stop_idx_q   <= 1'b0;
            state_q      <= S_STOP;
          end else begin
            count_q <= count_q + 1'b1;
          end
        end

        S_STOP: begin
          if (count_wrap_d) begin
            count_q <= '0;
            if (stop_idx_q == LAST_STOP) begin
              // Leave at mid-stop-bit so a back-to-back start edge is not missed.
              valid_q      <= 1'b1;
              data_q       <= shift_q;
              parity_out_q <= parity_err_q;
              stop_out_q   <= stop_err_q | ~sample_bit_d;
              parity_err_q <= 1'b0;
              stop_err_q   <= 1'b0;
              stop_idx_q   <= 1'b0;
              state_q      <= S_IDLE;
            end else begin
              stop_err_q <= stop_err_q | ~sample_bit_d;
              stop_idx_q <= stop_idx_q + 1'b1;
            end
          end else begin
            count_q <= count_q + 1'b1;
          end
        end

        default: begin
          count_q <= '0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign data_out_valid    = valid_q;
  assign data_out          = data_q;
  assign parity_error      = parity_out_q;
  assign stop_bit_unstable = stop_out_q;

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Directed bench for uart_rx_deserializer (16 clocks per bit, even parity, one stop bit).
module tb_uart_rx_deserializer;

  localparam int CPB     = 16;
  localparam int LATENCY = 171;

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       serr;
    int         cyc;
  } exp_t;

  logic       clock;
  logic       clear;
  logic       uart_rx;
  logic       data_out_valid;
  logic [7:0] data_out;
  logic       parity_error;
  logic       stop_bit_unstable;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  exp_t exp_q[$];

  uart_rx_deserializer #(
    .CLOCK_FREQUENCY   (16),
    .BAUD_RATE         (1),
    .INCLUDE_PARITY_BIT(1),
    .STOP_BITS         (1)
  ) dut (
    .clock            (clock),
    .clear            (clear),
    .uart_rx          (uart_rx),
    .data_out_valid   (data_out_valid),
    .data_out         (data_out),
    .parity_error     (parity_error),
    .stop_bit_unstable(stop_bit_unstable)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, {31'd0, data_out_valid}, 32'd0);
    check({tag, "_data"}, {24'd0, data_out}, 32'd0);
    check({tag, "_perr"}, {31'd0, parity_error}, 32'd0);
    check({tag, "_serr"}, {31'd0, stop_bit_unstable}, 32'd0);
  endtask

  task automatic drive_bit(input logic b, input int cycles);
    uart_rx = b;
    repeat (cycles) @(negedge clock);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pflip, input logic stopv);
    exp_t e;
    e.data = d;
    e.perr = pflip;
    e.serr = ~stopv;
    e.cyc  = cyc + LATENCY;
    exp_q.push_back(e);
    drive_bit(1'b0, CPB);
    for (int i = 0; i < 8; i++) drive_bit(d[i], CPB);
    drive_bit((^d) ^ pflip, CPB);
    drive_bit(stopv, CPB);
  endtask

  // Scoreboard: every valid pulse must match the oldest outstanding frame.
  always @(negedge clock) begin
    if (data_out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL unexpected_pulse: observed data %0h at cycle %0d expected no pulse", data_out, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("data_out", {24'd0, data_out}, {24'd0, e.data});
        check("parity_error", {31'd0, parity_error}, {31'd0, e.perr});
        check("stop_bit_unstable", {31'd0, stop_bit_unstable}, {31'd0, e.serr});
        check("pulse_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    #1_000_000;
    errors++;
    $error("FAIL watchdog: observed timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    clear   = 1'b0;
    uart_rx = 1'b1;
    @(negedge clock);
    for (int i = 0; i < 4; i++) begin
      check_idle("reset");
      @(negedge clock);
    end
    clear = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      check_idle("idle_after_reset");
    end

    send_frame(8'hA5, 1'b0, 1'b1);
    drive_bit(1'b1, 20);
    send_frame(8'hA5, 1'b1, 1'b1);
    drive_bit(1'b1, 20);

    send_frame(8'h3C, 1'b0, 1'b0);
    drive_bit(1'b1, 40);

    drive_bit(1'b0, 3);
    drive_bit(1'b1, 40);

    send_frame(8'h01, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b1);
    drive_bit(1'b1, 20);

    // 0x55 aborted by reset in the middle of data bit 4.
    drive_bit(1'b0, CPB);
    drive_bit(1'b1, CPB);
    drive_bit(1'b0, CPB);
    drive_bit(1'b1, CPB);
    drive_bit(1'b0, CPB);
    drive_bit(1'b1, CPB / 2);
    clear = 1'b0;
    @(negedge clock);
    check_idle("reset_mid_frame");
    clear   = 1'b1;
    uart_rx = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      check_idle("idle_after_abort");
    end

    send_frame(8'h80, 1'b0, 1'b1);
    drive_bit(1'b1, 40);

    check("pending_pulses", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
